// File: rtl/refemv_bus_ram_uart.sv
// refemv_bus_ram_uart: memory/IO stage behind the multi-cycle RV32I core.
// Provides word RAM, an LED register, a free-running cycle counter and an
// 8N1 UART transmitter. All accesses complete with fixed timing.
// The optional macro REFEMV_UART_FIFO_EN replaces the single holding byte
// with a 4-entry TX FIFO. The register map is the same in both builds.
module refemv_bus_ram_uart #(
   parameter int RAM_WORDS    = 1024,
   parameter     INIT_FILE    = "",
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wmask,
   input  logic        mem_rstrb,
   output logic [31:0] mem_rdata,
   output logic [7:0]  leds,
   output logic        uart_tx
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

   // ---------------- decode ----------------
   logic          io_sel;
   logic          ram_sel;
   logic [2:0]    io_reg;
   logic [AW-1:0] ram_idx;

   assign io_sel  = mem_addr[22];
   assign ram_sel = ~mem_addr[22];
   assign io_reg  = mem_addr[4:2];
   assign ram_idx = mem_addr[AW+1:2];

   // Only part of the address and store data is decoded.
   logic unused_bits;
   assign unused_bits = &{1'b0, mem_addr, mem_wdata};

   // ---------------- RAM ----------------
   logic [31:0] ram [RAM_WORDS];

   // Byte-lane write; no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (ram_sel && (mem_wmask != 4'b0000)) begin
         for (int l = 0; l < 4; l++) begin
            if (mem_wmask[l]) ram[ram_idx][8*l +: 8] <= mem_wdata[8*l +: 8];
         end
      end
   end

   // ---------------- IO registers ----------------
   logic [31:0] cycle_cnt;
   logic        tx_full;
   logic        tx_active;
   logic        uart_wr;
   logic        tx_push;
   logic        tx_pop;
   logic        tx_pending;
   logic [7:0]  tx_head;

   assign uart_wr = io_sel && (io_reg == 3'd1) && mem_wmask[0];
   assign tx_push = uart_wr && !tx_full;

   // LED register, written from byte lane 0.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                         leds <= 8'h00;
      else if (io_sel && (io_reg == 3'd0) && mem_wmask[0]) leds <= mem_wdata[7:0];
   end

   // Free-running cycle counter, wraps naturally.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cycle_cnt <= 32'd0;
      else       cycle_cnt <= cycle_cnt + 32'd1;
   end

   // IO read mux; sampled before any same-edge write takes effect.
   logic [31:0] io_rdata;
   always_comb begin
      io_rdata = 32'd0;
      case (io_reg)
         3'd0:    io_rdata = {24'd0, leds};
         3'd2:    io_rdata = {30'd0, tx_active, tx_full};
         3'd3:    io_rdata = cycle_cnt;
         default: io_rdata = 32'd0;
      endcase
   end

   // Read data register: loads on strobe, holds otherwise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)          mem_rdata <= 32'd0;
      else if (mem_rstrb) mem_rdata <= ram_sel ? ram[ram_idx] : io_rdata;
   end

   // ---------------- TX byte buffer ----------------
`ifdef REFEMV_UART_FIFO_EN
   logic [7:0] fifo_mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] fifo_cnt;

   // Full counts the byte in the shifter so four writes fill the queue.
   assign tx_full    = (fifo_cnt + {2'b00, tx_active}) >= 3'd4;
   assign tx_pending = (fifo_cnt != 3'd0);
   assign tx_head    = fifo_mem[rd_ptr];

   // FIFO storage, no reset needed.
   always_ff @(posedge clk) begin
      if (tx_push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         fifo_cnt <= 3'd0;
      end else begin
         if (tx_push) wr_ptr <= wr_ptr + 2'd1;
         if (tx_pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({tx_push, tx_pop})
            2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end
`else
   logic [7:0] hold_byte;
   logic       hold_vld;

   // Busy from the accepting edge until the stop bit finishes.
   assign tx_full    = hold_vld | tx_active;
   assign tx_pending = hold_vld;
   assign tx_head    = hold_byte;

   // Single holding byte; push and pop never coincide since push needs !full.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_byte <= 8'h00;
         hold_vld  <= 1'b0;
      end else if (tx_push) begin
         hold_byte <= mem_wdata[7:0];
         hold_vld  <= 1'b1;
      end else if (tx_pop) begin
         hold_vld  <= 1'b0;
      end
   end
`endif

   // ---------------- UART TX FSM ----------------
   tx_state_t     state, state_n;
   logic [CW-1:0] baud_cnt, baud_cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shreg, shreg_n;
   logic          tx_n;
   logic          baud_last;

   assign baud_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));
   assign tx_active = (state != S_IDLE);

   // FSM state and registered serial output.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         shreg    <= 8'h00;
         uart_tx  <= 1'b1;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_idx  <= bit_idx_n;
         shreg    <= shreg_n;
         uart_tx  <= tx_n;
      end
   end

   // Next state; line level follows the state being entered.
   always_comb begin
      state_n    = state;
      baud_cnt_n = baud_cnt;
      bit_idx_n  = bit_idx;
      shreg_n    = shreg;
      tx_pop     = 1'b0;
      case (state)
         S_IDLE: begin
            if (tx_pending) begin
               state_n    = S_START;
               baud_cnt_n = '0;
               shreg_n    = tx_head;
               tx_pop     = 1'b1;
            end
         end
         S_START: begin
            if (baud_last) begin
               state_n    = S_DATA;
               baud_cnt_n = '0;
               bit_idx_n  = 3'd0;
            end else begin
               baud_cnt_n = baud_cnt + CW'(1);
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_cnt_n = '0;
               shreg_n    = {1'b0, shreg[7:1]};
               if (bit_idx == 3'd7) state_n = S_STOP;
               else                 bit_idx_n = bit_idx + 3'd1;
            end else begin
               baud_cnt_n = baud_cnt + CW'(1);
            end
         end
         S_STOP: begin
            if (baud_last) begin
               baud_cnt_n = '0;
               if (tx_pending) begin
                  state_n = S_START;
                  shreg_n = tx_head;
                  tx_pop  = 1'b1;
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               baud_cnt_n = baud_cnt + CW'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase

      tx_n = 1'b1;
      if (state_n == S_START)     tx_n = 1'b0;
      else if (state_n == S_DATA) tx_n = shreg_n[0];
   end

endmodule

// File: tb/tb_refemv_bus_ram_uart.sv
// Self-checking bench for refemv_bus_ram_uart: directed and randomized bus
// traffic checked against a word-array RAM model and a bit-timing UART model.
module tb_refemv_bus_ram_uart;

   localparam int CPB = 4;
   localparam logic [31:0] IO = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wmask = '0;
   logic        mem_rstrb = 1'b0;
   logic [31:0] mem_rdata;
   logic [7:0]  leds;
   logic        uart_tx;

   int n_pass = 0;
   int n_chk  = 0;

   refemv_bus_ram_uart #(.RAM_WORDS(1024), .INIT_FILE(""), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rstn(rstn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
      .leds(leds), .uart_tx(uart_tx));

   always #5 clk = ~clk;

   // One bus cycle: drive at negedge, cross one posedge, return at negedge.
   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic r);
      mem_addr = a; mem_wdata = d; mem_wmask = m; mem_rstrb = r;
      @(posedge clk);
      @(negedge clk);
      mem_wmask = 4'b0000; mem_rstrb = 1'b0;
   endtask

   // Streams nw consecutive UART_DATA writes and checks the serial line
   // against the frames the buffer can accept (1 plain, 4 with the FIFO).
   task automatic uart_stream(input string nm, input logic [7:0] wb [5], input int nw);
      int cap, nf, total, bad, first_bad, m, f, b;
      logic e;
      logic [31:0] st_exp;
`ifdef REFEMV_UART_FIFO_EN
      cap = 4;
`else
      cap = 1;
`endif
      nf = (nw < cap) ? nw : cap;
      total = 2 + 40 * nf + 12;
      bad = 0; first_bad = -1;
      st_exp = {30'd0, 1'b1, (nf >= cap)};
      for (int c = 0; c < total; c++) begin
         m = c - 2;
         if (m >= 0 && m < 40 * nf) begin
            f = m / 40;
            b = (m % 40) / CPB;
            e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : wb[f][b-1];
         end else begin
            e = 1'b1;
         end
         if (uart_tx !== e) begin
            bad++;
            if (first_bad < 0) first_bad = c;
         end
         if (c == nw + 2) begin
            n_chk++;
            if (mem_rdata !== st_exp) $display("FAIL %s status busy: got %h expected %h", nm, mem_rdata, st_exp);
            else n_pass++;
         end
         mem_wmask = 4'b0000; mem_rstrb = 1'b0;
         if (c < nw) begin
            mem_addr = IO | 32'h4; mem_wdata = {4{wb[c]}}; mem_wmask = 4'b0001;
         end else if (c == nw + 1) begin
            mem_addr = IO | 32'h8; mem_rstrb = 1'b1;
         end
         @(negedge clk);
      end
      n_chk++;
      if (bad != 0) $display("FAIL %s line: %0d bad samples, first at cycle %0d, expected 0 bad", nm, bad, first_bad);
      else n_pass++;
      bus(IO | 32'h8, 32'd0, 4'b0000, 1'b1);
      n_chk++;
      if (mem_rdata !== 32'd0) $display("FAIL %s status idle: got %h expected 00000000", nm, mem_rdata);
      else n_pass++;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++; if (mem_rdata !== 32'd0) $display("FAIL reset rdata: got %h expected 0", mem_rdata); else n_pass++;
      n_chk++; if (leds !== 8'd0) $display("FAIL reset leds: got %h expected 0", leds); else n_pass++;
      n_chk++; if (uart_tx !== 1'b1) $display("FAIL reset uart_tx: got %b expected 1", uart_tx); else n_pass++;
      rstn = 1'b1;
      bus(IO | 32'hC, 32'd0, 4'b0000, 1'b1);
      n_chk++; if (mem_rdata !== 32'd0) $display("FAIL reset cycle start: got %h expected 0", mem_rdata); else n_pass++;
      bus(IO | 32'h8, 32'd0, 4'b0000, 1'b1);
      n_chk++; if (mem_rdata !== 32'd0) $display("FAIL reset status: got %h expected 0", mem_rdata); else n_pass++;
   endtask

   task automatic test_ram_lanes();
      bus(32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0);
      bus(32'h10, 32'h5555_5555, 4'b0010, 1'b0);
      bus(32'h10, 32'd0, 4'b0000, 1'b1);
      n_chk++; if (mem_rdata !== 32'hDEAD55EF) $display("FAIL ram lanes: got %h expected DEAD55EF", mem_rdata); else n_pass++;
      mem_addr = 32'h0040_000C;
      repeat (3) @(negedge clk);
      n_chk++; if (mem_rdata !== 32'hDEAD55EF) $display("FAIL ram hold: got %h expected DEAD55EF", mem_rdata); else n_pass++;
      bus(32'h1010, 32'd0, 4'b0000, 1'b1);
      n_chk++; if (mem_rdata !== 32'hDEAD55EF) $display("FAIL ram wrap: got %h expected DEAD55EF", mem_rdata); else n_pass++;
      bus(IO | 32'h10, 32'hFFFF_FFFF, 4'b1111, 1'b0);
      bus(32'h10, 32'd0, 4'b0000, 1'b1);
      n_chk++; if (mem_rdata !== 32'hDEAD55EF) $display("FAIL io write leaks to ram: got %h expected DEAD55EF", mem_rdata); else n_pass++;
      bus(IO | 32'h10, 32'd0, 4'b0000, 1'b1);
      n_chk++; if (mem_rdata !== 32'd0) $display("FAIL io reserved read: got %h expected 0", mem_rdata); else n_pass++;
      bus(IO | 32'h4, 32'd0, 4'b0000, 1'b1);
      n_chk++; if (mem_rdata !== 32'd0) $display("FAIL uart_data read: got %h expected 0", mem_rdata); else n_pass++;
   endtask

   task automatic test_ram_random();
      logic [31:0] model [16];
      logic [31:0] a, d, ex;
      logic [3:0]  m;
      logic        r;
      int          i;
      for (int k = 0; k < 16; k++) begin
         d = $urandom;
         a = {9'($urandom), 1'b0, 10'($urandom), 10'(64 + k), 2'b00};
         bus(a, d, 4'b1111, 1'b0);
         model[k] = d;
      end
      for (int n = 0; n < 40; n++) begin
         i  = $urandom_range(0, 15);
         m  = 4'($urandom);
         r  = ($urandom_range(0, 2) != 0);
         d  = $urandom;
         a  = {9'($urandom), 1'b0, 10'($urandom), 10'(64 + i), 2'($urandom)};
         ex = model[i];
         bus(a, d, m, r);
         for (int l = 0; l < 4; l++) if (m[l]) model[i][8*l +: 8] = d[8*l +: 8];
         if (r) begin
            n_chk++;
            if (mem_rdata !== ex) $display("FAIL ram random #%0d: got %h expected %h", n, mem_rdata, ex);
            else n_pass++;
         end
      end
   endtask

   task automatic test_leds();
      bus(IO, 32'h0000_00A5, 4'b0001, 1'b0);
      n_chk++; if (leds !== 8'hA5) $display("FAIL leds write: got %h expected A5", leds); else n_pass++;
      bus(IO, 32'd0, 4'b0000, 1'b1);
      n_chk++; if (mem_rdata !== 32'h0000_00A5) $display("FAIL leds read: got %h expected 000000A5", mem_rdata); else n_pass++;
      bus(IO | 32'h20, 32'h3C3C_3C3C, 4'b0001, 1'b1);
      n_chk++; if (mem_rdata !== 32'h0000_00A5) $display("FAIL leds rd/wr same edge: got %h expected 000000A5", mem_rdata); else n_pass++;
      n_chk++; if (leds !== 8'h3C) $display("FAIL leds aliased write: got %h expected 3C", leds); else n_pass++;
      bus(IO, 32'hFFFF_FFFF, 4'b1110, 1'b0);
      n_chk++; if (leds !== 8'h3C) $display("FAIL leds lane0 off: got %h expected 3C", leds); else n_pass++;
   endtask

   task automatic test_uart_frame();
      logic [7:0] wb [5];
      wb = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h00};
      uart_stream("frame41", wb, 1);
   endtask

   task automatic test_uart_overrun();
      logic [7:0] wb [5];
`ifdef REFEMV_UART_FIFO_EN
      wb = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
      uart_stream("overrun", wb, 5);
`else
      wb = '{8'h41, 8'h42, 8'h00, 8'h00, 8'h00};
      uart_stream("overrun", wb, 2);
`endif
   endtask

   task automatic test_uart_random();
      logic [7:0] wb [5];
      for (int n = 0; n < 2; n++) begin
         for (int k = 0; k < 5; k++) wb[k] = 8'($urandom);
         uart_stream("uart random", wb, $urandom_range(1, 3));
      end
   endtask

   task automatic test_counter();
      logic [31:0] a, b;
      bus(IO | 32'hC, 32'd0, 4'b0000, 1'b1);
      a = mem_rdata;
      repeat (9) @(negedge clk);
      bus(IO | 32'hC, 32'd0, 4'b0000, 1'b1);
      b = mem_rdata;
      n_chk++; if (b - a !== 32'd10) $display("FAIL cycle delta: got %0d expected 10", b - a); else n_pass++;
      force dut.cycle_cnt = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.cycle_cnt;
      mem_addr = IO | 32'hC; mem_rstrb = 1'b1;
      @(negedge clk);
      n_chk++; if (mem_rdata !== 32'hFFFF_FFFF) $display("FAIL cycle forced: got %h expected FFFFFFFF", mem_rdata); else n_pass++;
      @(negedge clk);
      mem_rstrb = 1'b0;
      n_chk++; if (mem_rdata !== 32'd0) $display("FAIL cycle wrap: got %h expected 0", mem_rdata); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] wb [5];
      bus(IO, 32'h0000_005A, 4'b0001, 1'b0);
      bus(IO, 32'd0, 4'b0000, 1'b1);
      n_chk++; if (mem_rdata !== 32'h5A) $display("FAIL pre-reset leds read: got %h expected 0000005A", mem_rdata); else n_pass++;
      bus(IO | 32'h4, 32'h0000_00C3, 4'b0001, 1'b0);
      repeat (12) @(negedge clk);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      n_chk++; if (uart_tx !== 1'b1) $display("FAIL async reset uart_tx: got %b expected 1", uart_tx); else n_pass++;
      n_chk++; if (leds !== 8'd0) $display("FAIL async reset leds: got %h expected 0", leds); else n_pass++;
      n_chk++; if (mem_rdata !== 32'd0) $display("FAIL async reset rdata: got %h expected 0", mem_rdata); else n_pass++;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 5; k++) wb[k] = 8'($urandom);
      uart_stream("after reset", wb, 1);
   endtask

   initial begin
      test_reset();
      test_ram_lanes();
      test_ram_random();
      test_leds();
      test_uart_frame();
      test_uart_overrun();
      test_uart_random();
      test_counter();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
